// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width convention, Gray/binary conversion
// and the overflow counter width.
package fifo_pkg;

    localparam int unsigned PTR_MAX_W = 32;
    localparam int unsigned OVF_CNT_W = 8;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int unsigned ptr_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin = '0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// STAGES-deep, WIDTH-bit synchronizer chain for Gray pointers crossing clock
// domains; shared by the write- and read-side flag controllers.
module ptr_sync #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_d;
    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = d_i;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/wr_flag_ctrl.sv
// Write-side async-FIFO controller: write pointer, read-pointer synchronizer,
// registered FULL/ALMOST_FULL/level and sticky overflow.
// Optional saturating overflow counter built only when FIFO_OVF_CNT_EN is defined.
module wr_flag_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_MARGIN   = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  WRITE_ENA,
    input  logic [ADDR_WIDTH:0]   RD_PTR_GRAY,
    input  logic                  OVF_CLR,
    output logic [ADDR_WIDTH-1:0] WRITE_ADDR,
    output logic                  WRITE_PUSH,
    output logic [ADDR_WIDTH:0]   WR_PTR_GRAY,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic [ADDR_WIDTH:0]   WR_LEVEL,
    output logic                  OVERFLOW,
    output logic [OVF_CNT_W-1:0]  OVF_COUNT
);

    localparam int unsigned PTR_W = ptr_width(ADDR_WIDTH);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PTR_W-1:0] LVL_FULL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LVL_AF   = PTR_W'(DEPTH - AF_MARGIN);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (AF_MARGIN < 1 || AF_MARGIN > DEPTH - 1) begin : g_bad_margin
        $error("AF_MARGIN must lie in 1..DEPTH-1");
    end

    logic [PTR_W-1:0] wptr_d, wptr_q;
    logic [PTR_W-1:0] wptr_gray_d, wptr_gray_q;
    logic [PTR_W-1:0] level_d, level_q;
    logic             full_d, full_q;
    logic             afull_d, afull_q;
    logic             ovf_d, ovf_q;
    logic [PTR_W-1:0] rptr_gray_s;
    logic [PTR_W-1:0] rptr_s;
    logic             write_push;
    logic             write_drop;

    ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .d_i    (RD_PTR_GRAY),
        .q_o    (rptr_gray_s)
    );

    assign rptr_s     = PTR_W'(gray2bin(PTR_MAX_W'(rptr_gray_s)));
    assign write_push = WRITE_ENA && !full_q;
    assign write_drop = WRITE_ENA && full_q;

    always_comb begin
        wptr_d      = wptr_q + PTR_W'(write_push);
        wptr_gray_d = PTR_W'(bin2gray(PTR_MAX_W'(wptr_d)));
        // Wrap bit makes the modular difference exact across pointer wrap.
        level_d     = wptr_d - rptr_s;
        full_d      = (level_d == LVL_FULL);
        afull_d     = (level_d >= LVL_AF);
        ovf_d       = ovf_q;
        if (write_drop) begin
            ovf_d = 1'b1;
        end else if (OVF_CLR) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr_q      <= '0;
            wptr_gray_q <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            wptr_gray_q <= wptr_gray_d;
            level_q     <= level_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef FIFO_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_d, ovf_cnt_q;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (write_drop) begin
            if (ovf_cnt_q != '1) begin
                ovf_cnt_d = ovf_cnt_q + 1'b1;
            end
        end else if (OVF_CLR) begin
            ovf_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign OVF_COUNT = ovf_cnt_q;
`else
    assign OVF_COUNT = '0;
`endif

    assign WRITE_ADDR  = wptr_q[ADDR_WIDTH-1:0];
    assign WRITE_PUSH  = write_push;
    assign WR_PTR_GRAY = wptr_gray_q;
    assign FULL        = full_q;
    assign ALMOST_FULL = afull_q;
    assign WR_LEVEL    = level_q;
    assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_wr_flag_ctrl.sv
// Randomized and directed bench for wr_flag_ctrl against a count-based
// reference model (DEPTH=8, AF_MARGIN=2, SYNC_STAGES=2).
module tb_wr_flag_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       WRITE_ENA = 1'b0;
    logic [3:0] RD_PTR_GRAY = '0;
    logic       OVF_CLR = 1'b0;
    logic [2:0] WRITE_ADDR;
    logic       WRITE_PUSH;
    logic [3:0] WR_PTR_GRAY;
    logic       FULL;
    logic       ALMOST_FULL;
    logic [3:0] WR_LEVEL;
    logic       OVERFLOW;
    logic [7:0] OVF_COUNT;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: total accepted writes, reads issued, and reads as seen
    // one and two edges ago (the synchronizer delay).
    int wcount, rcount, r_d1, r_d2;
    int exp_level, exp_cnt;
    bit exp_full, exp_af, exp_ovf;

    wr_flag_ctrl #(
        .ADDR_WIDTH  (3),
        .SYNC_STAGES (2),
        .AF_MARGIN   (2)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .WRITE_ENA   (WRITE_ENA),
        .RD_PTR_GRAY (RD_PTR_GRAY),
        .OVF_CLR     (OVF_CLR),
        .WRITE_ADDR  (WRITE_ADDR),
        .WRITE_PUSH  (WRITE_PUSH),
        .WR_PTR_GRAY (WR_PTR_GRAY),
        .FULL        (FULL),
        .ALMOST_FULL (ALMOST_FULL),
        .WR_LEVEL    (WR_LEVEL),
        .OVERFLOW    (OVERFLOW),
        .OVF_COUNT   (OVF_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] gray4(input int v);
        logic [3:0] b;
        b = 4'(v % 16);
        return b ^ (b >> 1);
    endfunction

    task automatic check_outputs();
        check_eq("level", WR_LEVEL, exp_level);
        check_eq("full", FULL, exp_full);
        check_eq("afull", ALMOST_FULL, exp_af);
        check_eq("wgray", WR_PTR_GRAY, gray4(wcount));
        check_eq("ovf", OVERFLOW, exp_ovf);
`ifdef FIFO_OVF_CNT_EN
        check_eq("ovf_cnt", OVF_COUNT, exp_cnt);
`else
        check_eq("ovf_cnt", OVF_COUNT, 0);
`endif
    endtask

    task automatic model_reset();
        wcount = 0; rcount = 0; r_d1 = 0; r_d2 = 0;
        exp_level = 0; exp_cnt = 0;
        exp_full = 0; exp_af = 0; exp_ovf = 0;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input bit en, input bit clr, input bit adv);
        if (adv && rcount < wcount) rcount++;
        WRITE_ENA   = en;
        OVF_CLR     = clr;
        RD_PTR_GRAY = gray4(rcount);
        #1;
        check_eq("push", WRITE_PUSH, en && !exp_full);
        check_eq("waddr", WRITE_ADDR, wcount % 8);
        @(posedge CLK);
        #1;
        if (en && !exp_full) wcount++;
        if (en && exp_full) begin
            exp_ovf = 1;
            if (exp_cnt < 255) exp_cnt++;
        end else if (clr) begin
            exp_ovf = 0;
            exp_cnt = 0;
        end
        exp_level = wcount - r_d2;
        r_d2 = r_d1;
        r_d1 = rcount;
        exp_full = (exp_level == 8);
        exp_af   = (exp_level >= 6);
        check_outputs();
    endtask

    task automatic do_reset();
        #3;
        RST_N = 1'b0;
        WRITE_ENA = 1'b0;
        OVF_CLR = 1'b0;
        RD_PTR_GRAY = '0;
        #1;
        model_reset();
        check_outputs();
        check_eq("rst_waddr", WRITE_ADDR, 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_outputs();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Mid-stream reset after 5 writes.
        repeat (5) step(1, 0, 0);
        do_reset();
        step(0, 0, 0);

        // Fill to FULL with the reader idle.
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0);
            if (i == 5) check_eq("af_after6", ALMOST_FULL, 1);
        end
        check_eq("full8", FULL, 1);
        check_eq("lvl8", WR_LEVEL, 8);
        check_eq("wgray8", WR_PTR_GRAY, 4'b1100);

        // Writes while FULL are dropped, then cleared.
        repeat (2) step(1, 0, 0);
        check_eq("ovf_set", OVERFLOW, 1);
        check_eq("wgray_hold", WR_PTR_GRAY, 4'b1100);
        step(0, 1, 0);
        check_eq("ovf_clr", OVERFLOW, 0);
        check_eq("cnt_clr", OVF_COUNT, 0);

        // One read releases FULL three edges later.
        step(0, 0, 1);
        check_eq("rel_hold1", FULL, 1);
        step(0, 0, 0);
        check_eq("rel_hold2", FULL, 1);
        step(0, 0, 0);
        check_eq("rel_full", FULL, 0);
        check_eq("rel_lvl", WR_LEVEL, 7);

        // Wrap-around with the reader trailing four behind.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            step(1, 0, (wcount - rcount) >= 4);
            check_eq("wrap_nofull", FULL, 0);
        end

        // Write and synchronized read land on the same edge at level 7.
        do_reset();
        repeat (7) step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        check_eq("simul_lvl", WR_LEVEL, 7);
        check_eq("simul_full", FULL, 0);

        // Randomized traffic with periodic resets.
        for (int i = 0; i < 1500; i++) begin
            if (i % 500 == 499) do_reset();
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
